lcd_pixel_fetcher: RTL
======================

Name: lcd_pixel_fetcher

Overview:
- Upstream feeder for the LCD pixel writer stage.
- Reads the framebuffer in raster order over a simple read-request/response memory port and buffers pixels in a show-ahead FIFO.
- Presents 24-bit rgb with data_valid to the writer and pops one pixel per clock in which the writer asserts data_req.
- Provides frame-boundary double-buffer switching and underflow reporting.

Parameters:
- HOR_PIX, 480, active pixels per line.
- VER_PIX, 272, active lines per frame.
- ADDR_W, 20, framebuffer word-address width (one pixel per word).
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, at least 4.
- LVL_W, $clog2(FIFO_DEPTH)+1, width of the fifo_level output.

Ports:
- clk_12mhz  in  1  system/pixel clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- enable  in  1  run fetching; sampled each cycle.
- fb_base  in  ADDR_W  framebuffer base address; latched only at frame start.
- mem_rd_req  out  1  read request valid.
- mem_rd_addr  out  ADDR_W  read address; stable while mem_rd_req is high and mem_rd_gnt is low.
- mem_rd_gnt  in  1  request accepted this cycle.
- mem_rd_valid  in  1  read data returning, in order.
- mem_rd_data  in  24  returned pixel {R[7:0],G[7:0],B[7:0]}.
- rgb  out  24  FIFO head pixel.
- data_valid  out  1  high when the FIFO is non-empty.
- data_req  in  1  writer consumes rgb this cycle if data_valid is high.
- frame_done  out  1  one-cycle pulse on the pop of the last pixel of a frame.
- underflow  out  1  sticky; data_req seen while the FIFO is empty and running.
- fifo_level  out  LVL_W  current FIFO occupancy.

Behaviour:
- Reset values (async, rst=0): mem_rd_req=0, mem_rd_addr=0, rgb=0, data_valid=0, frame_done=0, underflow=0, fifo_level=0; FIFO emptied; fetch, pop and in-flight counters cleared; state=IDLE.
- States:
  - IDLE: mem_rd_req=0. Go to FETCH when enable=1, latching base_q<=fb_base and fetch_idx<=0.
  - FETCH: request pixels in raster order. Go to IDLE when enable=0. Requests already accepted still complete and push, and the FIFO keeps draining.
- Address generation: mem_rd_addr = base_q + fetch_idx, truncated to ADDR_W (wraps modulo 2^ADDR_W). fetch_idx advances on each mem_rd_req&&mem_rd_gnt.
- Frame wrap: at fetch_idx = HOR_PIX*VER_PIX-1, an accepted request sets fetch_idx<=0 and base_q<=fb_base. This is the double-buffer swap; fb_base is never used mid-frame.
- Credit rule: inflight increments on req&&gnt and decrements on mem_rd_valid; both in one cycle leaves it unchanged.
  - mem_rd_req = (state==FETCH) && (fifo_level + inflight < FIFO_DEPTH).
  - The FIFO therefore can never overflow.
- Unsolicited return: mem_rd_valid while inflight==0 is dropped and not pushed; inflight stays at 0.
- Push: on mem_rd_valid, data is written at the tail. It is visible at rgb/data_valid the next cycle (1-cycle push-to-output latency).
- Pop: on data_req && data_valid, the head advances and rgb shows the next entry next cycle. rgb is the show-ahead head, registered.
- Simultaneous push and pop: fifo_level unchanged. Push into an empty FIFO with data_req high: no pop that cycle, because data_valid was 0.
- data_valid is high whenever fifo_level != 0, including writer porch periods. Pixels are consumed only when data_req is high.
- Pop counter counts 0..HOR_PIX*VER_PIX-1. The pop at the terminal value pulses frame_done for 1 cycle and the counter wraps to 0.
- underflow is set when data_req=1, fifo_level=0 and state==FETCH. It clears only on reset or on an IDLE->FETCH transition.
- enable deasserted mid-frame: fetch_idx and the pop counter hold. Re-enable restarts from fetch_idx=0 with a new base_q. The pop counter resets to 0 on that transition only if FIFO and inflight are both 0; otherwise the re-enable waits in IDLE until they drain.
- Reset mid-operation: everything returns to reset values immediately. In-flight responses arriving after reset are handled by the unsolicited-return rule.

Test Plan:
- Reset, then enable=1, fb_base=0x01000, gnt=1, 2-cycle read latency, data_req=0 -> exactly 16 requests issued at addresses 0x01000..0x0100F, then mem_rd_req=0; fifo_level=16; data_valid=1.
- From a full FIFO, data_req=1 for 4 cycles -> rgb shows entries 0..3 in order, fifo_level drops to 12, and 4 new requests follow at 0x01010..0x01013.
- HOR_PIX=4, VER_PIX=2, fb_base changed to 0x02000 mid-frame -> 8th request at 0x01007, 9th at 0x02000; frame_done pulses exactly on the 8th pop.
- mem_rd_gnt held low for 10 cycles with data_req=1 -> mem_rd_addr stable; FIFO drains to 0, then underflow=1 and stays 1 after gnt resumes.
- Same-cycle push and pop at fifo_level=5 -> fifo_level stays 5 and order is preserved; mem_rd_valid with inflight=0 -> ignored, level unchanged.
- Assert rst low with 3 requests in flight, release, return 3 stale responses -> all dropped, fifo_level=0, all outputs at reset values.

Source files
------------

// File: rtl/lcd_pixel_fetcher.sv
// Framebuffer reader for the LCD pixel writer: raster-order reads over a
// request/response port, buffered in a show-ahead FIFO with frame-boundary base swap.
module lcd_pixel_fetcher #(
  parameter int unsigned HOR_PIX    = 480,
  parameter int unsigned VER_PIX    = 272,
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_12mhz,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADDR_W-1:0] fb_base,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_gnt,
  input  logic              mem_rd_valid,
  input  logic [23:0]       mem_rd_data,
  output logic [23:0]       rgb,
  output logic              data_valid,
  input  logic              data_req,
  output logic              frame_done,
  output logic              underflow,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int unsigned PIX_W     = 24;
  localparam int unsigned FRAME_PIX = HOR_PIX * VER_PIX;
  localparam int unsigned IDX_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned SUM_W     = LVL_W + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [IDX_W-1:0]     fetch_idx_q, fetch_idx_d;
  logic [IDX_W-1:0]     pop_cnt_q, pop_cnt_d;
  logic [LVL_W-1:0]     inflight_q, inflight_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PIX_W-1:0]     rgb_q, rgb_d;
  logic                 dv_q, dv_d;
  logic                 frame_done_q, frame_done_d;
  logic                 underflow_q, underflow_d;
  logic [PIX_W-1:0]     mem_q [FIFO_DEPTH];

  logic [SUM_W-1:0]     credit_sum_c;
  logic                 req_c;
  logic                 acc_c;
  logic                 push_c;
  logic                 pop_c;
  logic [PTR_W-1:0]     rd_next_c;

  // Outstanding reads plus buffered pixels never exceed the FIFO depth.
  assign credit_sum_c = SUM_W'(level_q) + SUM_W'(inflight_q);
  assign req_c        = (state_q == ST_FETCH) && (credit_sum_c < SUM_W'(FIFO_DEPTH));
  assign acc_c        = req_c && mem_rd_gnt;
  // Responses with no read outstanding are stale (e.g. issued before a reset).
  assign push_c       = mem_rd_valid && (inflight_q != '0);
  assign pop_c        = data_req && dv_q;
  assign rd_next_c    = rd_ptr_q + PTR_W'(1);

  assign mem_rd_req  = req_c;
  assign mem_rd_addr = base_q + ADDR_W'(fetch_idx_q);
  assign rgb         = rgb_q;
  assign data_valid  = dv_q;
  assign frame_done  = frame_done_q;
  assign underflow   = underflow_q;
  assign fifo_level  = level_q;

  // Next-state: control FSM, address/pop counters, FIFO bookkeeping.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    fetch_idx_d  = fetch_idx_q;
    pop_cnt_d    = pop_cnt_q;
    inflight_d   = inflight_q;
    level_d      = level_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rgb_d        = rgb_q;
    frame_done_d = 1'b0;
    underflow_d  = underflow_q;

    if (acc_c) begin
      if (fetch_idx_q == IDX_W'(FRAME_PIX - 1)) begin
        fetch_idx_d = '0;
        base_d      = fb_base;
      end else begin
        fetch_idx_d = fetch_idx_q + IDX_W'(1);
      end
    end

    if (pop_c) begin
      if (pop_cnt_q == IDX_W'(FRAME_PIX - 1)) begin
        pop_cnt_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        pop_cnt_d = pop_cnt_q + IDX_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        // Restart only once everything from the previous run has drained.
        if (enable && (level_q == '0) && (inflight_q == '0)) begin
          state_d     = ST_FETCH;
          base_d      = fb_base;
          fetch_idx_d = '0;
          pop_cnt_d   = '0;
          underflow_d = 1'b0;
        end
      end
      ST_FETCH: begin
        if (data_req && (level_q == '0)) begin
          underflow_d = 1'b1;
        end
        if (!enable) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (acc_c && !push_c) begin
      inflight_d = inflight_q + LVL_W'(1);
    end else if (!acc_c && push_c) begin
      inflight_d = inflight_q - LVL_W'(1);
    end

    if (push_c && !pop_c) begin
      level_d = level_q + LVL_W'(1);
    end else if (!push_c && pop_c) begin
      level_d = level_q - LVL_W'(1);
    end

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_next_c;
    end

    // Registered show-ahead head: bypass the incoming word when it becomes the head.
    if (push_c && ((level_q == '0) || (pop_c && (level_q == LVL_W'(1))))) begin
      rgb_d = mem_rd_data;
    end else if (pop_c && (level_q > LVL_W'(1))) begin
      rgb_d = mem_q[rd_next_c];
    end

    dv_d = (level_d != '0);
  end

  always_ff @(posedge clk_12mhz or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      fetch_idx_q  <= '0;
      pop_cnt_q    <= '0;
      inflight_q   <= '0;
      level_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rgb_q        <= '0;
      dv_q         <= 1'b0;
      frame_done_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      fetch_idx_q  <= fetch_idx_d;
      pop_cnt_q    <= pop_cnt_d;
      inflight_q   <= inflight_d;
      level_q      <= level_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rgb_q        <= rgb_d;
      dv_q         <= dv_d;
      frame_done_q <= frame_done_d;
      underflow_q  <= underflow_d;
    end
  end

  // Pixel storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk_12mhz) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= mem_rd_data;
    end
  end

endmodule
